// File: rtl/axis_broadcast_fifo.sv
// -----------------------------------------------------------------------------
// axis_broadcast_fifo
//
// Copies one AXI-Stream slave input onto N_OUT master outputs, each with its
// own FIFO of DEPTH beats. A per-channel mask, taken from ch_mask on the first
// beat of a packet, picks which channels get the packet. Mask bits that change
// in the middle of a packet have no effect. An all-zero mask accepts the
// packet and drops it. Each channel drains on its own ready signal. The input
// stalls only when a channel that is active for the current packet is full.
//
// Optional feature (macro AXIS_BCAST_STATS_EN):
//   Adds output pkt_count. It holds a 32-bit wrapping counter per channel that
//   counts popped beats with tlast=1.
//
// Ports:
//   clock, reset           : sole clock (rising edge); asynchronous active-high reset
//   input_axis_*           : slave stream (tvalid/tready/tdata/tkeep/tid/tlast)
//   ch_mask [N_OUT]        : channel enable, sampled on the first beat of a packet
//   output_axis_tvalid/tready/tlast [N_OUT] : per-channel handshake and last
//   output_axis_tdata/tkeep/tid             : channel i packed at [i*W +: W]
//   pkt_count [N_OUT*32]   : (AXIS_BCAST_STATS_EN only) per-channel packet count
// -----------------------------------------------------------------------------
module axis_broadcast_fifo #(
    parameter int DATA_W = 512,
    parameter int ID_W   = 6,
    parameter int N_OUT  = 2,
    parameter int DEPTH  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      input_axis_tvalid,
    output logic                      input_axis_tready,
    input  logic [DATA_W-1:0]         input_axis_tdata,
    input  logic [DATA_W/8-1:0]       input_axis_tkeep,
    input  logic [ID_W-1:0]           input_axis_tid,
    input  logic                      input_axis_tlast,
    input  logic [N_OUT-1:0]          ch_mask,
    output logic [N_OUT-1:0]          output_axis_tvalid,
    input  logic [N_OUT-1:0]          output_axis_tready,
    output logic [N_OUT*DATA_W-1:0]   output_axis_tdata,
    output logic [N_OUT*DATA_W/8-1:0] output_axis_tkeep,
    output logic [N_OUT*ID_W-1:0]     output_axis_tid,
    output logic [N_OUT-1:0]          output_axis_tlast
`ifdef AXIS_BCAST_STATS_EN
    ,
    output logic [N_OUT*32-1:0]       pkt_count
`endif
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int EW     = DATA_W + KEEP_W + ID_W + 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_IN_PKT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_OUT-1:0] r_pkt_mask;
    logic [N_OUT-1:0] w_active_mask;
    logic [N_OUT-1:0] w_full;
    logic [N_OUT-1:0] w_push;
    logic             w_accept;
    logic [EW-1:0]    w_in_entry;

    assign w_in_entry = {input_axis_tdata, input_axis_tkeep, input_axis_tid, input_axis_tlast};

    // The first beat of a packet uses the live mask. Later beats use the
    // mask latched when that first beat was accepted.
    always_comb begin
        w_active_mask     = (r_state == S_IDLE) ? ch_mask : r_pkt_mask;
        // Full means occupancy==DEPTH at this moment. A pop in the same
        // cycle does not free the slot early, so tready has no path from the
        // output readies.
        input_axis_tready = ~reset & (&(~w_active_mask | ~w_full));
        w_accept          = input_axis_tvalid & input_axis_tready;
        w_push            = w_accept ? w_active_mask : '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = input_axis_tlast ? S_IDLE : S_IN_PKT;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pkt_mask <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && (r_state == S_IDLE)) begin
                r_pkt_mask <= ch_mask;
            end
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_ch
        logic [EW-1:0] r_mem [DEPTH];
        logic [AW-1:0] r_wr_ptr;
        logic [AW-1:0] r_rd_ptr;
        logic [CW-1:0] r_count;
        logic [EW-1:0] w_rd_entry;
        logic          w_pop;
        logic          w_valid;

        assign w_full[g]  = (r_count == CW'(DEPTH));
        assign w_valid    = ~reset & (r_count != '0);
        assign w_pop      = w_valid & output_axis_tready[g];
        assign w_rd_entry = r_mem[r_rd_ptr];

        // The storage has no reset. Only pointers and counts are cleared,
        // and the outputs are forced to zero while reset is high.
        always_ff @(posedge clock) begin
            if (w_push[g]) begin
                r_mem[r_wr_ptr] <= w_in_entry;
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push[g]) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
                case ({w_push[g], w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end

        assign output_axis_tvalid[g]                   = w_valid;
        assign output_axis_tdata[g*DATA_W +: DATA_W]   = reset ? '0 : w_rd_entry[EW-1 -: DATA_W];
        assign output_axis_tkeep[g*KEEP_W +: KEEP_W]   = reset ? '0 : w_rd_entry[ID_W+1 +: KEEP_W];
        assign output_axis_tid[g*ID_W +: ID_W]         = reset ? '0 : w_rd_entry[1 +: ID_W];
        assign output_axis_tlast[g]                    = reset ? 1'b0 : w_rd_entry[0];

`ifdef AXIS_BCAST_STATS_EN
        logic [31:0] r_pkt_cnt;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_pkt_cnt <= '0;
            end else if (w_pop && w_rd_entry[0]) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end

        assign pkt_count[g*32 +: 32] = r_pkt_cnt;
`endif
    end

endmodule
